// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared constants for the mux scan controller.
//   State encodings, channel count and field widths used by mux_scan_ctrl and settle_timer.
package mux_scan_pkg;

  localparam int unsigned CH_COUNT = 8;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned CNT_W    = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_HOLD   = 2'd3;

endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable down counter that times the settle interval after each sel change.
//   clk      rising-edge clock
//   rst      asynchronous active-high reset (count cleared)
//   load     load count with load_val (has priority over dec)
//   load_val value to load
//   dec      decrement by one (saturates at zero)
//   done     last settle cycle: the count is at one (or zero)
module settle_timer
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Loaded with SETTLE, so the cycle where the count reads one is the last settle cycle.
  assign done = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps an external 8-to-1 multiplexer through all channels, waits SETTLE
// cycles after each select change, samples the mux output and presents the assembled byte
// with a valid/ready handshake.
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   request one scan (only honoured in IDLE)
//   busy    scan in progress (decoded from state)
//   sel     multiplexer channel select
//   mux_in  multiplexer output
//   data    assembled scan, bit i sampled with sel==i
//   valid   data holds a complete scan
//   ready   consumer accepts data on valid&ready
//   parity  even parity of data (only when MUX_SCAN_PARITY_EN is defined)
// Build option: define MUX_SCAN_PARITY_EN to add the parity output.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic [SEL_W-1:0]    sel,
  input  logic                mux_in,
  output logic [CH_COUNT-1:0] data,
  output logic                valid,
  input  logic                ready
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                parity
`endif
);

  // With no settle time the controller goes straight from a sel change to sampling.
  localparam state_t AfterSel = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
  localparam logic [SEL_W-1:0] LastCh = SEL_W'(CH_COUNT - 1);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CH_COUNT-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                tmr_load, tmr_dec, tmr_done;

  settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (CNT_W'(SETTLE)),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    data_d   = data_q;
    valid_d  = valid_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sel_d    = '0;
          tmr_load = 1'b1;
          state_d  = AfterSel;
        end
      end
      ST_SETTLE: begin
        tmr_dec = 1'b1;
        if (tmr_done) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        data_d[sel_q] = mux_in;
        if (sel_q == LastCh) begin
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          sel_d    = sel_q + SEL_W'(1);
          tmr_load = 1'b1;
          state_d  = AfterSel;
        end
      end
      ST_HOLD: begin
        // A start arriving together with the accept is dropped; a new scan needs IDLE.
        if (ready) begin
          valid_d = 1'b0;
          sel_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign sel   = sel_q;
  assign data  = data_q;
  assign valid = valid_q;

`ifdef MUX_SCAN_PARITY_EN
  logic parity_q;

  // Captured from the completed byte on the edge valid rises, then held through HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (valid_d && !valid_q) begin
      parity_q <= ^data_d;
    end
  end

  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // dut1: SETTLE=1, dut0: SETTLE=0 (ready tied high)
  logic       start1, ready1, mux_in1, busy1, valid1;
  logic [2:0] sel1;
  logic [7:0] data1, pat1;
  logic       start0, ready0, mux_in0, busy0, valid0;
  logic [2:0] sel0;
  logic [7:0] data0, pat0;
`ifdef MUX_SCAN_PARITY_EN
  logic       parity1, parity0;
`endif

  // Behavioural 8-to-1 multiplexers driven by the bench patterns.
  assign mux_in1 = pat1[sel1];
  assign mux_in0 = pat0[sel0];

  mux_scan_ctrl #(.SETTLE(1)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .start  (start1),
    .busy   (busy1),
    .sel    (sel1),
    .mux_in (mux_in1),
    .data   (data1),
    .valid  (valid1),
    .ready  (ready1)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .parity (parity1)
`endif
  );

  mux_scan_ctrl #(.SETTLE(0)) dut0 (
    .clk    (clk),
    .rst    (rst),
    .start  (start0),
    .busy   (busy0),
    .sel    (sel0),
    .mux_in (mux_in0),
    .data   (data0),
    .valid  (valid0),
    .ready  (ready0)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .parity (parity0)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    start1 = 1'b0; ready1 = 1'b0; pat1 = 8'h00;
    start0 = 1'b0; ready0 = 1'b1; pat0 = 8'h00;

    // Reset state before any clock edge.
    #1;
    chk("rst_sel", sel1, 0);
    chk("rst_data", data1, 0);
    chk("rst_valid", valid1, 0);
    chk("rst_busy", busy1, 0);
`ifdef MUX_SCAN_PARITY_EN
    chk("rst_parity", parity1, 0);
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();

    // SETTLE=1 scan of A5: sel advances every 2 cycles, valid after 16.
    pat1 = 8'hA5;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("a5_sel0", sel1, 0);
    chk("a5_busy", busy1, 1);
    for (int j = 1; j < 16; j++) begin
      tick();
      chk("a5_sel", sel1, j / 2);
      chk("a5_novalid", valid1, 0);
    end
    tick();
    chk("a5_valid", valid1, 1);
    chk("a5_data", data1, 8'hA5);
    chk("a5_sel7", sel1, 7);
    chk("a5_busy_hold", busy1, 0);
`ifdef MUX_SCAN_PARITY_EN
    chk("a5_parity", parity1, 0);
`endif

    // HOLD with ready low and start pulsing: nothing moves.
    for (int i = 0; i < 20; i++) begin
      start1 = (i % 2 == 0);
      tick();
      chk("hold_valid", valid1, 1);
      chk("hold_data", data1, 8'hA5);
      chk("hold_busy", busy1, 0);
    end
    // Accept with start in the same cycle: back to IDLE, start ignored.
    ready1 = 1'b1;
    start1 = 1'b1;
    tick();
    ready1 = 1'b0;
    start1 = 1'b0;
    chk("acc_valid", valid1, 0);
    chk("acc_busy", busy1, 0);
    chk("acc_sel", sel1, 0);
    tick();
    chk("acc_nostart", busy1, 0);

    // Input changes between ch3 and ch4 samples: 0F then F0 gives FF.
    pat1 = 8'h0F;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int j = 1; j <= 8; j++) tick();
    chk("mid_partial", data1, 8'hAF);
    pat1 = 8'hF0;
    for (int j = 9; j <= 16; j++) tick();
    chk("mid_valid", valid1, 1);
    chk("mid_data", data1, 8'hFF);
`ifdef MUX_SCAN_PARITY_EN
    chk("mid_parity", parity1, 0);
`endif
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;

    // Unsampled channels keep previous-scan bits.
    pat1 = 8'h00;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    chk("keep_data", data1, 8'hFE);
    for (int j = 3; j <= 16; j++) tick();
    chk("zero_valid", valid1, 1);
    chk("zero_data", data1, 8'h00);
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;

    // Reset in the middle of a scan of FF.
    pat1 = 8'hFF;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int j = 1; j <= 8; j++) tick();
    chk("abort_partial", data1, 8'h0F);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_sel", sel1, 0);
    chk("abort_data", data1, 0);
    chk("abort_valid", valid1, 0);
    chk("abort_busy", busy1, 0);
`ifdef MUX_SCAN_PARITY_EN
    chk("abort_parity", parity1, 0);
`endif
    tick();
    tick();
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      tick();
      chk("abort_idle", {busy1, valid1}, 0);
    end
    pat1 = 8'h3C;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int j = 1; j <= 16; j++) tick();
    chk("fresh_valid", valid1, 1);
    chk("fresh_data", data1, 8'h3C);
`ifdef MUX_SCAN_PARITY_EN
    chk("fresh_parity", parity1, 0);
`endif
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;

    // SETTLE=0, ready tied high: one-cycle valid 8 cycles after start.
    pat0 = 8'h01;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("s0_sel0", sel0, 0);
    chk("s0_busy", busy0, 1);
    for (int j = 1; j < 8; j++) begin
      tick();
      chk("s0_sel", sel0, j);
      chk("s0_novalid", valid0, 0);
    end
    tick();
    chk("s0_valid", valid0, 1);
    chk("s0_data", data0, 8'h01);
`ifdef MUX_SCAN_PARITY_EN
    chk("s0_parity", parity0, 1);
`endif
    tick();
    chk("s0_valid_drop", valid0, 0);
    chk("s0_idle_sel", sel0, 0);
    chk("s0_idle_busy", busy0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 1, idle cycles after each sel change before sampling (legal 0..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request one 8-channel scan; honoured only in IDLE.
REQ-005 busy  output  1  high in SETTLE/SAMPLE states.
REQ-006 sel  output  3  channel select driven to the 8-to-1 multiplexer's select input.
REQ-007 mux_in  input  1  multiplexer output, sampled in SAMPLE.
REQ-008 data  output  8  assembled scan; bit i = sample taken with sel==i.
REQ-009 valid  output  1  data holds a complete scan.
REQ-010 ready  input  1  consumer accepts data when valid&ready.
REQ-011 parity  output  1  even parity of data; present only with MUX_SCAN_PARITY_EN.

Function
REQ-012 FSM states SHALL be IDLE, SETTLE, SAMPLE, HOLD.
REQ-013 IDLE, start=1: sel<=0, settle counter<=SETTLE, next SETTLE (SAMPLE directly if SETTLE==0).
REQ-014 SETTLE SHALL last exactly SETTLE cycles per channel, sel stable, then go to SAMPLE.
REQ-015 SAMPLE (one cycle): data[sel]<=mux_in; if sel==7 next HOLD with valid<=1, else sel<=sel+1, reload counter, next SETTLE.
REQ-016 Timing: start sampled at edge k SHALL cause channel i to be sampled at edge k+(i+1)*(SETTLE+1); valid high after edge k+8*(SETTLE+1).
REQ-017 HOLD: valid, data, parity SHALL stay stable until valid&ready at a clock edge; then valid<=0, next IDLE.
REQ-018 valid&ready and start in the same cycle: accept data, return to IDLE, ignore start (new scan needs start in IDLE).
REQ-019 start outside IDLE SHALL be ignored; no queuing.
REQ-020 sel SHALL never exceed 7 and SHALL not wrap during a scan; sel holds 7 in HOLD, 0 in IDLE.
REQ-021 data bits of channels not yet sampled in the current scan SHALL keep previous-scan values; data is valid only while valid=1.
REQ-022 busy = (state==SETTLE)|(state==SAMPLE); valid=1 only in HOLD.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, sel=0, data=0, valid=0, busy=0, parity=0, counter=0, regardless of clock.
REQ-024 rst mid-scan SHALL abort the scan with no valid pulse; first start after rst release begins a fresh scan.

Configuration
REQ-025 MUX_SCAN_PARITY_EN defined: port parity = XOR of data, registered in the same edge valid rises, held in HOLD.
REQ-026 MUX_SCAN_PARITY_EN undefined: parity port and logic absent; all other behaviour identical.

Structure
REQ-027 Shared package mux_scan_pkg SHALL hold state encodings (IDLE=0, SETTLE=1, SAMPLE=2, HOLD=3), CH_COUNT=8, SEL_W=3, CNT_W=4.
REQ-028 Sub-module settle_timer (loadable 4-bit down counter, load/done) SHALL implement the settle counter.
REQ-029 Total RTL 120-400 lines; outputs registered except busy (decoded from state).

Verification
REQ-030 SETTLE=1, mux driven by I=8'hA5, start pulse -> sel steps 0..7 every 2 cycles, valid after 16 cycles, data=8'hA5, parity=0 (macro on).
REQ-031 SETTLE=0, I=8'h01, ready tied 1 -> valid for exactly 1 cycle 8 cycles after start, data=8'h01, parity=1.
REQ-032 ready held 0 for 20 cycles in HOLD, start pulsed repeatedly -> data/valid stable, no new scan; ready=1 -> IDLE next cycle.
REQ-033 rst asserted after sample 3 of scan with I=8'hFF -> all outputs 0 asynchronously, no valid; next scan with I=8'h3C yields 8'h3C.
REQ-034 I changed from 8'h0F to 8'hF0 between sel=3 and sel=4 samples -> data=8'hFF (each bit reflects its own sample instant).
REQ-035 Build without MUX_SCAN_PARITY_EN, rerun REQ-030 -> identical data/valid/sel timing, no parity port.
